// File: rtl/esc_pkg.sv
// Shared definitions for the ESC control slice: scheduler state encoding,
// PWM/budget defaults shared with timing_hub, and the duty word width.
package esc_pkg;

    localparam int PWM_TICKS_DEF      = 4096;
    localparam int COMPUTE_BUDGET_DEF = 416;
    localparam int N_STAGES_DEF       = 3;
    localparam int DUTY_W_DEF         = 12;
    localparam int BUDGET_W           = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ABORT = 2'd3
    } sched_state_t;

    // Saturating increment for the budget counter.
    function automatic logic [BUDGET_W-1:0] sat_inc(input logic [BUDGET_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/duty_shadow_bank.sv
// Shadow bank for the three phase duties: captures a finished computation,
// commits it to the comparators at PWM wrap, and zeroes everything on fault.
module duty_shadow_bank
    import esc_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF
) (
    input  logic                clk_ctrl,
    input  logic                rst_ctrl_n,
    input  logic                capture,
    input  logic                wrap,
    input  logic                fault,
    input  logic [3*DUTY_W-1:0] duty_in,
    output logic [3*DUTY_W-1:0] duty_out,
    output logic                commit,
    output logic                shadow_valid
);

    logic [3*DUTY_W-1:0] shadow;

    // NOTE: the shadow bank is a handful of flops, not a RAM, so it is reset
    // along with everything else; a memory array would be left unreset.
    always_ff @(posedge clk_ctrl or negedge rst_ctrl_n) begin
        if (!rst_ctrl_n) begin
            shadow       <= '0;
            shadow_valid <= 1'b0;
            duty_out     <= '0;
            commit       <= 1'b0;
        end else if (fault) begin
            shadow_valid <= 1'b0;
            duty_out     <= '0;
            commit       <= 1'b0;
        end else begin
            commit <= wrap && shadow_valid;
            if (wrap && shadow_valid) begin
                duty_out     <= shadow;
                shadow_valid <= 1'b0;
            end
            // A capture on the wrap edge is written last so its valid flag
            // survives the clear above and waits for the following wrap.
            if (capture) begin
                shadow       <= duty_in;
                shadow_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/compute_sched.sv
// Per-PWM-period compute sequencer: runs N_STAGES stages via start/done,
// enforces COMPUTE_BUDGET, and hands finished duties to the shadow bank.
// Optional COMPUTE_SCHED_STATS_EN adds saturating overrun/drop counters.
module compute_sched
    import esc_pkg::*;
#(
    parameter int PWM_TICKS      = PWM_TICKS_DEF,
    parameter int COMPUTE_BUDGET = COMPUTE_BUDGET_DEF,
    parameter int N_STAGES       = N_STAGES_DEF,
    parameter int DUTY_W         = DUTY_W_DEF
) (
    input  logic                clk_ctrl,
    input  logic                rst_ctrl_n,
    input  logic [11:0]         pwm_ctr,
    input  logic                compute_trig,
    input  logic                hub_fault,
    output logic                stage_start,
    output logic [1:0]          stage_sel,
    input  logic                stage_done,
    input  logic [3*DUTY_W-1:0] duty_in,
    output logic [3*DUTY_W-1:0] duty_out,
    output logic                commit,
    output logic                busy,
    output logic                overrun,
    output logic                trig_drop
`ifdef COMPUTE_SCHED_STATS_EN
    ,
    output logic [7:0]          overrun_cnt,
    output logic [7:0]          drop_cnt
`endif
);

    localparam logic [1:0]          LAST_SEL    = 2'(N_STAGES - 1);
    localparam logic [BUDGET_W-1:0] BUDGET_LAST = BUDGET_W'(COMPUTE_BUDGET - 1);
    localparam logic [11:0]         WRAP_VAL    = 12'(PWM_TICKS - 1);

    sched_state_t          state_q, state_d;
    logic [1:0]            sel_q, sel_d;
    logic [BUDGET_W-1:0]   budget_q, budget_d;
    logic                  start_d;
    logic                  capture;
    logic                  expire;
    logic                  last_stage;
    logic                  shadow_valid;

    assign busy       = (state_q == ST_START) || (state_q == ST_WAIT);
    assign last_stage = (sel_q == LAST_SEL);
    assign stage_sel  = sel_q;
    // The counter reaches the budget on the edge that ends this cycle.
    assign expire     = (budget_q >= BUDGET_LAST);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        budget_d  = busy ? sat_inc(budget_q) : budget_q;
        start_d   = 1'b0;
        capture   = 1'b0;
        overrun   = 1'b0;
        trig_drop = 1'b0;

        if (hub_fault) begin
            state_d = ST_IDLE;
        end else begin
            trig_drop = compute_trig && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (compute_trig) begin
                        state_d  = ST_START;
                        budget_d = '0;
                        sel_d    = '0;
                    end
                end
                ST_START: begin
                    if (expire) begin
                        overrun = 1'b1;
                        state_d = ST_ABORT;
                    end else begin
                        start_d = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A final done on the expiry cycle beats the overrun.
                    if (stage_done && !last_stage) begin
                        sel_d   = sel_q + 2'd1;
                        state_d = ST_START;
                    end else if (stage_done) begin
                        capture = 1'b1;
                        state_d = ST_IDLE;
                    end else if (expire) begin
                        overrun = 1'b1;
                        state_d = ST_ABORT;
                    end
                end
                ST_ABORT: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_ctrl or negedge rst_ctrl_n) begin
        if (!rst_ctrl_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            budget_q    <= '0;
            stage_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            budget_q    <= budget_d;
            stage_start <= start_d;
        end
    end

    duty_shadow_bank #(
        .DUTY_W (DUTY_W)
    ) u_bank (
        .clk_ctrl     (clk_ctrl),
        .rst_ctrl_n   (rst_ctrl_n),
        .capture      (capture),
        .wrap         (pwm_ctr == WRAP_VAL),
        .fault        (hub_fault),
        .duty_in      (duty_in),
        .duty_out     (duty_out),
        .commit       (commit),
        .shadow_valid (shadow_valid)
    );

`ifdef COMPUTE_SCHED_STATS_EN
    always_ff @(posedge clk_ctrl or negedge rst_ctrl_n) begin
        if (!rst_ctrl_n) begin
            overrun_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            if (overrun && (overrun_cnt != 8'hFF))
                overrun_cnt <= overrun_cnt + 8'd1;
            if (trig_drop && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_compute_sched.sv
// Directed bench for compute_sched: table of full computations plus
// hand-written fault, wrap-capture and reset sequences.
module tb_compute_sched;

    logic        clk_ctrl = 1'b0;
    logic        rst_ctrl_n;
    logic [11:0] pwm_ctr;
    logic        compute_trig;
    logic        hub_fault;
    logic        stage_start;
    logic [1:0]  stage_sel;
    logic        stage_done;
    logic [35:0] duty_in;
    logic [35:0] duty_out;
    logic        commit;
    logic        busy;
    logic        overrun;
    logic        trig_drop;
`ifdef COMPUTE_SCHED_STATS_EN
    logic [7:0]  overrun_cnt;
    logic [7:0]  drop_cnt;
`endif

    compute_sched dut (
        .clk_ctrl     (clk_ctrl),
        .rst_ctrl_n   (rst_ctrl_n),
        .pwm_ctr      (pwm_ctr),
        .compute_trig (compute_trig),
        .hub_fault    (hub_fault),
        .stage_start  (stage_start),
        .stage_sel    (stage_sel),
        .stage_done   (stage_done),
        .duty_in      (duty_in),
        .duty_out     (duty_out),
        .commit       (commit),
        .busy         (busy),
        .overrun      (overrun),
        .trig_drop    (trig_drop)
`ifdef COMPUTE_SCHED_STATS_EN
        ,
        .overrun_cnt  (overrun_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk_ctrl = ~clk_ctrl;

    typedef struct {
        string       name;
        int          lat0, lat1, lat2;   // stage latencies, 0 = never completes
        int          trig_pwm;
        int          trig2_off;          // extra trigger offset, 0 = none
        logic [35:0] duty;
        int          s0, s1, s2;         // expected stage_start offsets, -1 = none
        int          ovr_off;
        int          commit_off;
        int          drop_off;
        logic [35:0] exp_duty;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pend_done = -1;
    int lat0, lat1, lat2, lat_sel;
    int start_q[$], ovr_q[$], commit_q[$], drop_q[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input string name, input int l0, input int l1, input int l2,
                                input int tp, input int t2, input logic [35:0] d,
                                input int s0, input int s1, input int s2, input int ov,
                                input int cm, input int dr, input logic [35:0] ed);
        vec_t v;
        v.name = name; v.lat0 = l0; v.lat1 = l1; v.lat2 = l2;
        v.trig_pwm = tp; v.trig2_off = t2; v.duty = d;
        v.s0 = s0; v.s1 = s1; v.s2 = s2; v.ovr_off = ov;
        v.commit_off = cm; v.drop_off = dr; v.exp_duty = ed;
        return v;
    endfunction

    function automatic int rel_at(input int q[$], input int i, input int t);
        if (i < q.size()) return q[i] - t;
        return -1;
    endfunction

    // One clock: inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_ctrl);
        #1;
        cyc++;
        pwm_ctr    = pwm_ctr + 12'd1;
        stage_done = (cyc == pend_done);
    endtask

    task automatic clear_log();
        start_q.delete(); ovr_q.delete(); commit_q.delete(); drop_q.delete();
        pend_done = -1;
    endtask

    // Event log plus a stage model answering each start after its latency.
    always @(negedge clk_ctrl) begin
        if (rst_ctrl_n) begin
            if (stage_start) begin
                start_q.push_back(cyc);
                lat_sel = (stage_sel == 2'd0) ? lat0 : (stage_sel == 2'd1) ? lat1 : lat2;
                pend_done = (lat_sel > 0) ? cyc + lat_sel : -1;
            end
            if (overrun)   ovr_q.push_back(cyc);
            if (commit)    commit_q.push_back(cyc);
            if (trig_drop) drop_q.push_back(cyc);
        end
    end

    task automatic run_vec(input vec_t v);
        int t;
        clear_log();
        lat0 = v.lat0; lat1 = v.lat1; lat2 = v.lat2;
        duty_in = v.duty;
        step();
        pwm_ctr = 12'(v.trig_pwm);
        compute_trig = 1'b1;
        t = cyc;
        while (cyc - t < 4096 - v.trig_pwm + 3) begin
            step();
            compute_trig = (v.trig2_off != 0) && (cyc - t == v.trig2_off);
        end
        check({v.name, "/n_start"}, 64'(start_q.size()), 64'((v.s0 >= 0) + (v.s1 >= 0) + (v.s2 >= 0)));
        check({v.name, "/start0"},  64'(rel_at(start_q, 0, t)), 64'(v.s0));
        check({v.name, "/start1"},  64'(rel_at(start_q, 1, t)), 64'(v.s1));
        check({v.name, "/start2"},  64'(rel_at(start_q, 2, t)), 64'(v.s2));
        check({v.name, "/overrun"}, 64'(rel_at(ovr_q, 0, t)), 64'(v.ovr_off));
        check({v.name, "/n_ovr"},   64'(ovr_q.size()), 64'(v.ovr_off >= 0));
        check({v.name, "/commit"},  64'(rel_at(commit_q, 0, t)), 64'(v.commit_off));
        check({v.name, "/n_commit"}, 64'(commit_q.size()), 64'(v.commit_off >= 0));
        check({v.name, "/drop"},    64'(rel_at(drop_q, 0, t)), 64'(v.drop_off));
        check({v.name, "/duty_out"}, 64'(duty_out), 64'(v.exp_duty));
        check({v.name, "/busy_end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int t;
        // name, lat0..2, trig_pwm, trig2, duty, s0..s2, ovr, commit, drop, exp duty
        vecs[0] = mk("nominal",   50, 50, 50,  1000, 0,  36'h123456789, 2, 54, 106, -1,  3096, -1, 36'h123456789);
        vecs[1] = mk("busy_trig", 50, 50, 50,  3000, 20, 36'h0AB0CD0EF, 2, 54, 106, -1,  1096, 20, 36'h0AB0CD0EF);
        vecs[2] = mk("overrun",   50, 50, 0,   3000, 0,  36'hAAABBBCCC, 2, 54, 106, 416, -1,   -1, 36'h0AB0CD0EF);
        vecs[3] = mk("tie",       50, 50, 310, 3000, 0,  36'h0FFF0000F, 2, 54, 106, -1,  1096, -1, 36'h0FFF0000F);
        vecs[4] = mk("late1",     50, 50, 311, 3000, 0,  36'h555666777, 2, 54, 106, 416, -1,   -1, 36'h0FFF0000F);
        vecs[5] = mk("fast",      1,  1,  1,   3500, 0,  36'hFFF000FFF, 2, 5,  8,   -1,  596,  -1, 36'hFFF000FFF);

        rst_ctrl_n = 1'b0; pwm_ctr = '0; compute_trig = 1'b0; hub_fault = 1'b0;
        stage_done = 1'b0; duty_in = '0; lat0 = 0; lat1 = 0; lat2 = 0;
        repeat (3) step();
        check("rst_duty", 64'(duty_out), 64'd0);
        check("rst_ctrl_outs", 64'({commit, busy, overrun, trig_drop, stage_start, stage_sel}), 64'd0);
        rst_ctrl_n = 1'b1;
        repeat (2) step();
        check("post_rst_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
`ifdef COMPUTE_SCHED_STATS_EN
        check("stats_overrun_cnt", 64'(overrun_cnt), 64'd2);
        check("stats_drop_cnt", 64'(drop_cnt), 64'd1);
`endif

        // Fault in WAIT with an uncommitted capture pending.
        clear_log();
        lat0 = 5; lat1 = 5; lat2 = 5; duty_in = 36'h111222333;
        step(); pwm_ctr = 12'd100; compute_trig = 1'b1; t = cyc;
        repeat (30) begin step(); compute_trig = 1'b0; end
        check("flt_pre_commit", 64'(commit_q.size()), 64'd0);
        lat0 = 50;
        step(); compute_trig = 1'b1; t = cyc;
        while (cyc - t < 10) begin step(); compute_trig = 1'b0; end
        check("flt_busy_before", 64'(busy), 64'd1);
        hub_fault = 1'b1;
        step();
        check("flt_duty_zero", 64'(duty_out), 64'd0);
        check("flt_idle", 64'(busy), 64'd0);
        check("flt_no_commit_pulse", 64'(commit), 64'd0);
        compute_trig = 1'b1;
        step(); compute_trig = 1'b0;
        check("flt_trig_ignored", 64'(busy), 64'd0);
        repeat (5) step();
        hub_fault = 1'b0;
        while (pwm_ctr != 12'd5 && cyc - t < 5000) step();
        check("flt_starts", 64'(start_q.size()), 64'd4);
        check("flt_no_drop", 64'(drop_q.size()), 64'd0);
        check("flt_no_commit", 64'(commit_q.size()), 64'd0);
        check("flt_duty_held", 64'(duty_out), 64'd0);

        // Final done lands on the wrap cycle: commit waits a full period.
        clear_log();
        lat0 = 5; lat1 = 5; lat2 = 5; duty_in = 36'h789ABCDEF;
        step(); pwm_ctr = 12'd4074; compute_trig = 1'b1; t = cyc;
        while (cyc - t < 30) begin step(); compute_trig = 1'b0; end
        check("wrap_cap_no_early_commit", 64'(commit_q.size()), 64'd0);
        check("wrap_cap_duty_old", 64'(duty_out), 64'd0);
        while (commit_q.size() == 0 && cyc - t < 4200) step();
        check("wrap_cap_commit", 64'(rel_at(commit_q, 0, t)), 64'd4118);
        check("wrap_cap_duty_new", 64'(duty_out), 64'h789ABCDEF);

        // Asynchronous reset while waiting on the last stage.
        clear_log();
        lat0 = 5; lat1 = 5; lat2 = 50;
        step(); compute_trig = 1'b1; t = cyc;
        while (cyc - t < 20) begin step(); compute_trig = 1'b0; end
        check("rst_pre_sel", 64'(stage_sel), 64'd2);
        check("rst_pre_busy", 64'(busy), 64'd1);
        #3 rst_ctrl_n = 1'b0;
        #1;
        check("rst_mid_duty", 64'(duty_out), 64'd0);
        check("rst_mid_outs", 64'({commit, busy, overrun, trig_drop, stage_start, stage_sel}), 64'd0);
        repeat (2) step();
        rst_ctrl_n = 1'b1;
        pend_done = -1;
        repeat (3) step();
        check("rst_after_busy", 64'(busy), 64'd0);
`ifdef COMPUTE_SCHED_STATS_EN
        check("rst_stats", 64'({overrun_cnt, drop_cnt}), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
